matrix_scan: RTL and testbench

Downstream consumer of the video stage's serial pixel stream: one monochrome pixel and its 8-bit address per clock, covering a 16x16 frame in continuous 0..255 order. The block reassembles complete frames and holds them tear-free in a ready store. It then drives a row-multiplexed 16x16 LED matrix: one-hot row select, 16-bit column data, with a blanking gap between rows. Frames are swapped only at scan-frame boundaries.

---
 rtl/video_pkg.sv | 16 +
 rtl/pix_capture.sv | 72 +++++++
 rtl/matrix_scan.sv | 102 ++++++++++
 tb/tb_matrix_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video stage and its LED-matrix consumer.
package video_pkg;

  localparam int SCREEN_W = 16;
  localparam int SCREEN_H = 16;
  localparam int PIX_AW   = 8;

  typedef enum logic {
    S_BLANK,
    S_ON
  } scan_state_t;

  // One full frame: [row][column], column bit 15 is the leftmost pixel.
  typedef logic [SCREEN_H-1:0][SCREEN_W-1:0] frame_t;

endpackage

// File: rtl/pix_capture.sv
// Pixel-stream capture: tracks address continuity, assembles frames in a
// shadow store and hands completed frames to a ready store.
module pix_capture
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              to_vram,
  input  logic [PIX_AW-1:0] vram_addr,
  input  logic              consume,
  output frame_t            ready,
  output logic              ready_valid,
  output logic              sync_err,
  output logic [7:0]        drop_count
);

  localparam logic [PIX_AW-1:0] LAST_ADDR = '1;

  logic              armed;
  logic [PIX_AW-1:0] expect_addr;
  frame_t            shadow;
  frame_t            shadow_next;
  logic              in_seq;
  logic              capture;
  logic              complete;
  logic [3:0]        pix_row;
  logic [3:0]        pix_col;

  // Address 0 always (re)starts a frame, otherwise only the expected address
  // is accepted while armed; 255 is only reachable in sequence.
  assign in_seq   = armed && (vram_addr == expect_addr);
  assign capture  = in_seq || (vram_addr == '0);
  assign complete = capture && (vram_addr == LAST_ADDR);
  assign pix_row  = vram_addr[7:4];
  assign pix_col  = ~vram_addr[3:0];

  // Shadow contents with the current pixel merged in.
  always_comb begin
    // NOTE: default assignment first so no path leaves shadow_next unassigned (no latch).
    shadow_next = shadow;
    if (capture) shadow_next[pix_row][pix_col] = to_vram;
  end

  // Arm/sync tracking, frame stores, ready hand-off and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      expect_addr <= '0;
      // NOTE: the frame stores are reset because a reset must blank the display content too.
      shadow      <= '0;
      ready       <= '0;
      ready_valid <= 1'b0;
      sync_err    <= 1'b0;
      drop_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      armed       <= capture;
      expect_addr <= vram_addr + 1'b1;
      sync_err    <= armed && !in_seq;
      if (capture) shadow <= shadow_next;
      if (complete) begin
        ready       <= shadow_next;
        ready_valid <= 1'b1;
        if (ready_valid && !consume && (drop_count != 8'hFF))
          drop_count <= drop_count + 8'd1;
      end else if (consume) begin
        ready_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// Row-multiplexed 16x16 LED matrix driver: blank/lit scan per row, with the
// displayed frame swapped from the ready store only at scan-frame boundaries.
module matrix_scan
  import video_pkg::*;
#(
  parameter int DWELL = 64,
  parameter int BLANK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              to_vram,
  input  logic [PIX_AW-1:0] vram_addr,
  output logic [15:0]       row_sel,
  output logic [15:0]       col_data,
  output logic              frame_done,
  output logic              sync_err,
  output logic [7:0]        frame_count,
  output logic [7:0]        drop_count
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ROW_W   = $clog2(SCREEN_H);

  localparam logic [CW-1:0]    DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]    BLANK_LAST = CW'(BLANK - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(SCREEN_H - 1);

  scan_state_t      state;
  logic [CW-1:0]    cnt;
  logic [ROW_W-1:0] row;
  frame_t           front;
  frame_t           ready;
  logic             ready_valid;
  logic             boundary;
  logic             consume;

  // Last lit cycle of row 15 is where a waiting frame is taken for display.
  assign boundary = (state == S_ON) && (cnt == DWELL_LAST) && (row == ROW_LAST);
  assign consume  = boundary && ready_valid;

  pix_capture u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .to_vram     (to_vram),
    .vram_addr   (vram_addr),
    .consume     (consume),
    .ready       (ready),
    .ready_valid (ready_valid),
    .sync_err    (sync_err),
    .drop_count  (drop_count)
  );

  // Scan FSM with registered row/column drive and frame swap at the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BLANK;
      cnt         <= '0;
      row         <= '0;
      front       <= '0;
      row_sel     <= '0;
      col_data    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt      <= '0;
            state    <= S_ON;
            row_sel  <= 16'(1) << row;
            col_data <= front[row];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ON: begin
          if (cnt == DWELL_LAST) begin
            cnt      <= '0;
            state    <= S_BLANK;
            row_sel  <= '0;
            col_data <= '0;
            row      <= row + 1'b1;
            if (consume) begin
              front       <= ready;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan at default DWELL/BLANK.
module tb_matrix_scan;

  localparam int DWELL  = 64;
  localparam int BLANK  = 4;
  localparam int ROW_P  = DWELL + BLANK;
  localparam int FRAME  = 16 * ROW_P;

  logic        clk;
  logic        rst_n;
  logic        to_vram;
  logic [7:0]  vram_addr;
  logic [15:0] row_sel;
  logic [15:0] col_data;
  logic        frame_done;
  logic        sync_err;
  logic [7:0]  frame_count;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_sync   = 0;

  matrix_scan #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .to_vram     (to_vram),
    .vram_addr   (vram_addr),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_done  (frame_done),
    .sync_err    (sync_err),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected row drive n edges after reset release.
  function automatic logic [15:0] exp_row(input int n);
    int j  = n % ROW_P;
    int rr = (n / ROW_P) % 16;
    return (j >= BLANK) ? (16'(1) << rr) : 16'h0000;
  endfunction

  // Row pattern for each stimulus frame kind.
  function automatic logic [15:0] exp_col(input int kind, input int r);
    case (kind)
      0:       return (r == 0) ? 16'h8000 : 16'h0000;
      1:       return 16'hFFFF;
      2:       return (r % 2 == 0) ? 16'hAAAA : 16'h5555;
      default: return (16'(1) << r) ^ 16'hF000;
    endcase
  endfunction

  function automatic logic pix(input int kind, input int a);
    logic [15:0] rp;
    rp = exp_col(kind, a / 16);
    return rp[15 - (a % 16)];
  endfunction

  task automatic tick();
    logic [15:0] er;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done) n_done++;
    if (sync_err) n_sync++;
    er = exp_row(cyc);
    check("row_sel", 32'(row_sel), 32'(er));
    if (er == 16'h0000) check("col_blank", 32'(col_data), 32'h0);
  endtask

  task automatic idle();
    vram_addr = 8'hFF;
    to_vram   = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic stream(input int kind);
    for (int a = 0; a < 256; a++) begin
      vram_addr = 8'(a);
      to_vram   = pix(kind, a);
      tick();
    end
    idle();
  endtask

  task automatic check_rows(input int base, input int kind);
    for (int r = 0; r < 16; r++) begin
      run_to(base + r * ROW_P + 10);
      check("col_row", 32'(col_data), 32'(exp_col(kind, r)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    check("rst_row_sel", 32'(row_sel), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Reset asynchronously while row 7 is lit.
    run_to(7 * ROW_P + 30);
    check("row7_lit", 32'(row_sel), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_row_sel", 32'(row_sel), 32'h0);
    check("arst_col_data", 32'(col_data), 32'h0);
    check("arst_frame_done", 32'(frame_done), 32'h0);
    check("arst_sync_err", 32'(sync_err), 32'h0);
    check("arst_frame_count", 32'(frame_count), 32'h0);
    check("arst_drop_count", 32'(drop_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cyc    = 0;
    n_done = 0;
    n_sync = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("first_row", 32'(row_sel), (i == 4) ? 32'h0001 : 32'h0);
    end

    // Single pixel at address 0, shown after the first boundary.
    run_to(4);
    stream(0);
    check("drop_after_first", 32'(drop_count), 32'h0);
    run_to(FRAME - 1);
    check("no_done_early", 32'(n_done), 32'h0);
    tick();
    check("frame_done_1", 32'(frame_done), 32'h1);
    check("frame_count_1", 32'(frame_count), 32'h1);
    check_rows(FRAME, 0);
    check("done_one_pulse", 32'(n_done), 32'h1);

    // Address discontinuity: 0..99 then 101.
    n_done = 0;
    n_sync = 0;
    run_to(2200);
    for (int a = 0; a < 100; a++) begin
      vram_addr = 8'(a);
      to_vram   = 1'b1;
      tick();
    end
    vram_addr = 8'd101;
    tick();
    check("sync_err_pulse", 32'(sync_err), 32'h1);
    idle();
    run_to(3 * FRAME + 6);
    check("sync_err_once", 32'(n_sync), 32'h1);
    check("no_done_partial", 32'(n_done), 32'h0);
    check("count_hold", 32'(frame_count), 32'h1);

    // Clean frame after the error loads normally.
    run_to(3300);
    stream(3);
    run_to(4 * FRAME - 1);
    tick();
    check("frame_done_2", 32'(frame_done), 32'h1);
    check("frame_count_2", 32'(frame_count), 32'h2);
    check_rows(4 * FRAME, 3);

    // Two back-to-back frames inside one scan frame: the first is dropped.
    run_to(5 * FRAME + 10);
    n_sync = 0;
    stream(1);
    check("drop_none_yet", 32'(drop_count), 32'h0);
    stream(2);
    check("drop_one", 32'(drop_count), 32'h1);
    check("no_sync_b2b", 32'(n_sync), 32'h0);
    run_to(6 * FRAME - 1);
    tick();
    check("frame_done_3", 32'(frame_done), 32'h1);
    check("frame_count_3", 32'(frame_count), 32'h3);
    check_rows(6 * FRAME, 2);
    check("drop_still_one", 32'(drop_count), 32'h1);

    // Address 255 captured on the boundary edge with nothing ready.
    n_done = 0;
    run_to(8 * FRAME - 256);
    stream(1);
    check("edge_cyc", 32'(cyc), 32'(8 * FRAME));
    check("no_swap_at_edge", 32'(frame_done), 32'h0);
    check("count_at_edge", 32'(frame_count), 32'h3);
    run_to(9 * FRAME - 1);
    check("no_done_between", 32'(n_done), 32'h0);
    tick();
    check("frame_done_4", 32'(frame_done), 32'h1);
    check("frame_count_4", 32'(frame_count), 32'h4);
    check_rows(9 * FRAME, 1);
    check("drop_final", 32'(drop_count), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
